// File: rtl/irq_pkg.sv
// Shared defaults and FSM state type for the interrupt controller.
// Pure declarations: no logic, no latency, no flow control.
package irq_pkg;

    localparam int          NUM_SRC_DEF    = 4;
    localparam logic [31:0] ISR_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] ISR_STRIDE_DEF = 32'h0000_0010;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_ACTIVE
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over a request vector.
// Latency: purely combinational. Backpressure: none, because the requests are level inputs.
module irq_prio_enc #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: pending latch, mask, single-level ISR context, EPC capture.
// Latency: a source edge reaches irq 1 cycle later, and entry/resume take effect at the sampling edge. Backpressure: none; entry is ignored unless irq is high and the controller is idle.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_SRC    = NUM_SRC_DEF,
    parameter logic [31:0] ISR_BASE   = ISR_BASE_DEF,
    parameter logic [31:0] ISR_STRIDE = ISR_STRIDE_DEF,
    localparam int         IW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               irq_entry,
    input  logic               irq_resume,
    input  logic [31:0]        pc_ret,
    output logic               irq,
    output logic               irq_active,
    output logic [IW-1:0]      irq_id,
    output logic [31:0]        isr_vector,
    output logic [31:0]        epc,
    output logic [NUM_SRC-1:0] pending
);

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] enabled;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pending_d;
    logic               win_vld;
    logic [IW-1:0]      win_idx;
    logic               take;
    irq_state_t         state, state_d;

    assign src_edge = irq_src & ~src_q;
    assign enabled  = pending & irq_mask;
    assign irq      = |enabled;

    irq_prio_enc #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_prio (
        .req   (enabled),
        .valid (win_vld),
        .idx   (win_idx)
    );

    always_comb begin
        state_d = state;
        take    = 1'b0;
        case (state)
            IRQ_IDLE: begin
                if (irq_entry && win_vld) begin
                    state_d = IRQ_ACTIVE;
                    take    = 1'b1;
                end
            end
            IRQ_ACTIVE: begin
                if (irq_resume) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    // The edge term is ORed in after the clear, so a new edge on the serviced source stays pending.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = take && (win_idx == IW'(i));
        end
        pending_d = (pending & ~clr) | src_edge;
    end

    always_ff @(posedge clk) begin
        src_q <= irq_src;
        if (rst) begin
            pending <= '0;
            state   <= IRQ_IDLE;
            irq_id  <= '0;
            epc     <= '0;
        end else begin
            pending <= pending_d;
            state   <= state_d;
            if (take) begin
                epc    <= pc_ret;
                irq_id <= win_idx;
            end
        end
    end

    assign irq_active = (state == IRQ_ACTIVE);
    assign isr_vector = ISR_BASE + 32'(irq_id) * ISR_STRIDE;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with the default 4-source configuration.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_src;
    logic [3:0]  irq_mask;
    logic        irq_entry;
    logic        irq_resume;
    logic [31:0] pc_ret;
    logic        irq;
    logic        irq_active;
    logic [1:0]  irq_id;
    logic [31:0] isr_vector;
    logic [31:0] epc;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .irq_mask   (irq_mask),
        .irq_entry  (irq_entry),
        .irq_resume (irq_resume),
        .pc_ret     (pc_ret),
        .irq        (irq),
        .irq_active (irq_active),
        .irq_id     (irq_id),
        .isr_vector (isr_vector),
        .epc        (epc),
        .pending    (pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_src = 4'b0010; irq_mask = 4'hF;
        irq_entry = 1'b0; irq_resume = 1'b0; pc_ret = 32'h0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (isr_vector !== 32'h100) begin errors++; $display("FAIL reset_vec got=%h exp=00000100", isr_vector); end
        checks++; if (irq_active !== 1'b0 || epc !== 32'h0 || irq_id !== 2'd0) begin
            errors++; $display("FAIL reset_state got act=%b epc=%h id=%0d exp act=0 epc=0 id=0", irq_active, epc, irq_id);
        end
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        checks++; if (irq !== 1'b1 || pending !== 4'b0100) begin
            errors++; $display("FAIL single_req got irq=%b pend=%b exp irq=1 pend=0100", irq, pending);
        end
        irq_entry = 1'b1; pc_ret = 32'h40;
        tick();
        irq_entry = 1'b0;
        checks++; if (irq_active !== 1'b1 || irq_id !== 2'd2) begin
            errors++; $display("FAIL single_entry got act=%b id=%0d exp act=1 id=2", irq_active, irq_id);
        end
        checks++; if (isr_vector !== 32'h120 || epc !== 32'h40 || pending !== 4'b0000) begin
            errors++; $display("FAIL single_ctx got vec=%h epc=%h pend=%b exp vec=120 epc=40 pend=0000", isr_vector, epc, pending);
        end
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
        checks++; if (irq_active !== 1'b0 || epc !== 32'h40 || irq_id !== 2'd2) begin
            errors++; $display("FAIL single_resume got act=%b epc=%h id=%0d exp act=0 epc=40 id=2", irq_active, epc, irq_id);
        end
    endtask

    task automatic test_back_to_back();
        irq_src = 4'b1010;
        tick();
        irq_src = 4'b0000;
        checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL b2b_pend got=%b exp=1010", pending); end
        irq_entry = 1'b1; pc_ret = 32'h80;
        tick();
        irq_entry = 1'b0;
        checks++; if (irq_id !== 2'd1 || pending !== 4'b1000) begin
            errors++; $display("FAIL b2b_first got id=%0d pend=%b exp id=1 pend=1000", irq_id, pending);
        end
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
        checks++; if (irq !== 1'b1 || irq_active !== 1'b0) begin
            errors++; $display("FAIL b2b_resume got irq=%b act=%b exp irq=1 act=0", irq, irq_active);
        end
        irq_entry = 1'b1; pc_ret = 32'h84;
        tick();
        irq_entry = 1'b0;
        checks++; if (irq_id !== 2'd3 || isr_vector !== 32'h130 || epc !== 32'h84 || pending !== 4'b0000) begin
            errors++; $display("FAIL b2b_second got id=%0d vec=%h epc=%h pend=%b exp id=3 vec=130 epc=84 pend=0000",
                               irq_id, isr_vector, epc, pending);
        end
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
    endtask

    task automatic test_mask();
        irq_mask = 4'hE; irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        checks++; if (pending !== 4'b0001 || irq !== 1'b0) begin
            errors++; $display("FAIL mask_hold got pend=%b irq=%b exp pend=0001 irq=0", pending, irq);
        end
        // An entry while the only pending source is masked must be ignored.
        irq_entry = 1'b1; pc_ret = 32'h300;
        tick();
        irq_entry = 1'b0;
        checks++; if (irq_active !== 1'b0 || pending !== 4'b0001) begin
            errors++; $display("FAIL mask_entry got act=%b pend=%b exp act=0 pend=0001", irq_active, pending);
        end
        irq_mask = 4'hF;
        #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq got=%b exp=1", irq); end
        irq_entry = 1'b1; pc_ret = 32'h90;
        tick();
        irq_entry = 1'b0;
        checks++; if (irq_id !== 2'd0 || isr_vector !== 32'h100 || epc !== 32'h90) begin
            errors++; $display("FAIL unmask_entry got id=%0d vec=%h epc=%h exp id=0 vec=100 epc=90", irq_id, isr_vector, epc);
        end
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
    endtask

    task automatic test_no_nest();
        irq_src = 4'b1000;
        tick();
        irq_src = 4'b0000;
        irq_entry = 1'b1; pc_ret = 32'hC0;
        tick();
        irq_entry = 1'b0;
        irq_src = 4'b0010;
        tick();
        irq_src = 4'b0000;
        irq_entry = 1'b1; pc_ret = 32'hFF;
        tick();
        irq_entry = 1'b0;
        checks++; if (irq_active !== 1'b1 || irq_id !== 2'd3 || epc !== 32'hC0 || pending !== 4'b0010) begin
            errors++; $display("FAIL nest_ignored got act=%b id=%0d epc=%h pend=%b exp act=1 id=3 epc=c0 pend=0010",
                               irq_active, irq_id, epc, pending);
        end
        irq_resume = 1'b1;
        tick();
        tick();
        irq_resume = 1'b0;
        checks++; if (irq_active !== 1'b0 || irq_id !== 2'd3 || epc !== 32'hC0 || pending !== 4'b0010) begin
            errors++; $display("FAIL idle_resume got act=%b id=%0d epc=%h pend=%b exp act=0 id=3 epc=c0 pend=0010",
                               irq_active, irq_id, epc, pending);
        end
        irq_entry = 1'b1; pc_ret = 32'hA0;
        tick();
        irq_entry = 1'b0;
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
    endtask

    task automatic test_set_wins();
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0100; irq_entry = 1'b1; pc_ret = 32'hB0;
        tick();
        irq_entry = 1'b0; irq_src = 4'b0000;
        checks++; if (irq_active !== 1'b1 || irq_id !== 2'd2 || pending !== 4'b0100) begin
            errors++; $display("FAIL set_wins got act=%b id=%0d pend=%b exp act=1 id=2 pend=0100", irq_active, irq_id, pending);
        end
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
        irq_entry = 1'b1; pc_ret = 32'hB4;
        tick();
        irq_entry = 1'b0;
        irq_resume = 1'b1;
        tick();
        irq_resume = 1'b0;
    endtask

    task automatic test_rst_mid();
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        irq_entry = 1'b1; pc_ret = 32'hDEAD_0000;
        tick();
        irq_entry = 1'b0;
        irq_src = 4'b1000;
        tick();
        checks++; if (irq_active !== 1'b1 || epc !== 32'hDEAD_0000 || pending !== 4'b1000) begin
            errors++; $display("FAIL pre_rst got act=%b epc=%h pend=%b exp act=1 epc=dead0000 pend=1000", irq_active, epc, pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (irq_active !== 1'b0 || epc !== 32'h0 || pending !== 4'b0000 || irq_id !== 2'd0) begin
            errors++; $display("FAIL rst_mid got act=%b epc=%h pend=%b id=%0d exp act=0 epc=0 pend=0000 id=0",
                               irq_active, epc, pending, irq_id);
        end
        // src3 was held high through reset, so no edge may be seen afterwards.
        tick();
        checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin
            errors++; $display("FAIL rst_hold got pend=%b irq=%b exp pend=0000 irq=0", pending, irq);
        end
        irq_src = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_no_nest();
        test_set_wins();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
